reg_bank_bus: RTL and testbench

//   Parametrised general-purpose register bank with an integrated shared-bus driver mux.

---
 rtl/reg_bank_bus.sv | 86 ++++++++
 tb/tb_reg_bank_bus.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/reg_bank_bus.sv
// General-purpose register bank with a priority-resolved shared-bus driver,
// register-sourced {sign, zero} flags and a sticky multi-driver detector.
module reg_bank_bus #(
  parameter int NREG  = 3,
  parameter int WIDTH = 8,
  parameter int BUS_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREG-1:0]         load,
  input  logic [NREG-1:0]         inc,
  input  logic [NREG-1:0]         dec,
  input  logic [NREG-1:0]         en,
  input  logic [NREG-1:0]         flag_load,
  input  logic                    ext_en,
  input  logic [BUS_W-1:0]        ext_data,
  input  logic                    hold,
  input  logic                    clr_conflict,
  output logic [BUS_W-1:0]        bus,
  output logic [NREG*WIDTH-1:0]   regs,
  output logic [1:0]              flags,
  output logic                    conflict
);

  localparam int CW = $clog2(NREG + 2) + 1;

  logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [1:0]                 flags_q, flags_d;
  logic                       conflict_q, conflict_d;
  logic [WIDTH-1:0]           flag_src;
  logic [CW-1:0]              drivers;

  // Descending scan so the lowest enabled index overrides everything else.
  always_comb begin
    bus = ext_en ? ext_data : '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (en[i]) bus = BUS_W'(regs_q[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (!hold) begin
        if (load[i])               regs_d[i] = bus[WIDTH-1:0];
        else if (inc[i] && !dec[i]) regs_d[i] = regs_q[i] + 1'b1;
        else if (dec[i] && !inc[i]) regs_d[i] = regs_q[i] - 1'b1;
      end
    end
  end

  // Flags see the pre-edge register value, never the one being written.
  always_comb begin
    flag_src = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (flag_load[i]) flag_src = regs_q[i];
    end
    flags_d = flags_q;
    if (!hold && (|flag_load)) flags_d = {flag_src[WIDTH-1], (flag_src == '0)};
  end

  always_comb begin
    drivers = CW'(ext_en);
    for (int i = 0; i < NREG; i++) drivers = drivers + CW'(en[i]);
    conflict_d = conflict_q;
    if (drivers > CW'(1))   conflict_d = 1'b1;
    else if (clr_conflict)  conflict_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '0;
      flags_q    <= 2'b00;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      flags_q    <= flags_d;
      conflict_q <= conflict_d;
    end
  end

  assign regs     = regs_q;
  assign flags    = flags_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_reg_bank_bus.sv
// Directed bench for reg_bank_bus (NREG=3, WIDTH=8, BUS_W=16).
module tb_reg_bank_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  load, inc, dec, en, flag_load;
  logic        ext_en;
  logic [15:0] ext_data;
  logic        hold, clr_conflict;
  logic [15:0] bus;
  logic [23:0] regs;
  logic [1:0]  flags;
  logic        conflict;

  int checks   = 0;
  int failures = 0;

  reg_bank_bus #(.NREG(3), .WIDTH(8), .BUS_W(16)) dut (
    .clk(clk), .rst(rst), .load(load), .inc(inc), .dec(dec), .en(en),
    .flag_load(flag_load), .ext_en(ext_en), .ext_data(ext_data), .hold(hold),
    .clr_conflict(clr_conflict), .bus(bus), .regs(regs), .flags(flags),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    load = '0; inc = '0; dec = '0; en = '0; flag_load = '0;
    ext_en = 1'b0; ext_data = '0; hold = 1'b0; clr_conflict = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_load(input logic [2:0] ld, input logic [15:0] d);
    ext_en = 1'b1; ext_data = d; load = ld;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    chk("rst_regs", 32'(regs), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_conflict", 32'(conflict), 32'h0);
    chk("rst_bus", 32'(bus), 32'h0);
    step();
    rst = 1'b0;

    // external load into reg0
    ext_en = 1'b1; ext_data = 16'h12A5; load = 3'b001;
    #1;
    chk("ext_bus", 32'(bus), 32'h12A5);
    step();
    idle();
    chk("ext_reg0", 32'(regs[7:0]), 32'hA5);
    chk("ext_noconf", 32'(conflict), 32'h0);

    ext_load(3'b010, 16'h003C);
    chk("reg1_3c", 32'(regs[15:8]), 32'h3C);

    // two register drivers, reg0 wins, reg2 captures
    en = 3'b011; load = 3'b100;
    #1;
    chk("xfer_bus", 32'(bus), 32'h00A5);
    step();
    idle();
    chk("xfer_regs", 32'(regs), 32'hA53CA5);
    chk("conf_set", 32'(conflict), 32'h1);
    step();
    chk("conf_sticky", 32'(conflict), 32'h1);
    en = 3'b001; ext_en = 1'b1; clr_conflict = 1'b1;
    step();
    idle();
    chk("conf_set_wins", 32'(conflict), 32'h1);
    clr_conflict = 1'b1;
    step();
    idle();
    chk("conf_clear", 32'(conflict), 32'h0);

    // wrap and flags
    ext_load(3'b010, 16'h00FF);
    inc = 3'b010;
    step();
    idle();
    chk("inc_wrap", 32'(regs[15:8]), 32'h00);
    flag_load = 3'b010;
    step();
    idle();
    chk("flags_zero", 32'(flags), 32'h1);
    flag_load = 3'b011;
    step();
    idle();
    chk("flags_prio", 32'(flags), 32'h2);
    dec = 3'b010; flag_load = 3'b010;
    step();
    idle();
    chk("dec_wrap", 32'(regs[15:8]), 32'hFF);
    chk("flags_preedge", 32'(flags), 32'h1);
    flag_load = 3'b010;
    step();
    idle();
    chk("flags_sign", 32'(flags), 32'h2);

    // load beats inc; inc&dec holds
    ext_en = 1'b1; ext_data = 16'h0040; load = 3'b010; inc = 3'b010;
    step();
    idle();
    chk("load_over_inc", 32'(regs[15:8]), 32'h40);
    inc = 3'b010; dec = 3'b010;
    step();
    idle();
    chk("incdec_hold", 32'(regs[15:8]), 32'h40);
    flag_load = 3'b010;
    step();
    idle();
    chk("flags_40", 32'(flags), 32'h0);

    // hold freezes state, not bus or conflict
    chk("pre_hold_conf", 32'(conflict), 32'h0);
    hold = 1'b1; en = 3'b001; ext_en = 1'b1; ext_data = 16'h0077;
    load = 3'b001; inc = 3'b100; flag_load = 3'b001;
    #1;
    chk("hold_bus", 32'(bus), 32'h00A5);
    step();
    idle();
    chk("hold_regs", 32'(regs), 32'hA540A5);
    chk("hold_flags", 32'(flags), 32'h0);
    chk("hold_conf", 32'(conflict), 32'h1);

    // asynchronous reset between edges during a transfer
    en = 3'b001; load = 3'b010;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_regs", 32'(regs), 32'h0);
    chk("arst_flags", 32'(flags), 32'h0);
    chk("arst_conf", 32'(conflict), 32'h0);
    idle();
    #1;
    chk("arst_bus", 32'(bus), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_regs", 32'(regs), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
